// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode encoding and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    // Shifted partial remainder needs WIDTH+1 bits; bit WIDTH of diff is the borrow.
    diff    = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    qbit    = 1'b0;
    acc_out = '0;
    if (is_div) begin
      qbit    = ~diff[WIDTH];
      acc_out = {(qbit ? diff[WIDTH-1:0] : acc_in[2*WIDTH-2:WIDTH-1]),
                 acc_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Handshake: a request is taken on a rising edge where op_valid && op_ready && !flush.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, step_acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem, step_q;

  logic               accept, is_md, div_op, signed_op, dz_now;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign accept    = op_valid && op_ready && !flush;
  assign is_md     = (op[2] == 1'b0);
  assign div_op    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign dz_now    = div_op && (src2 == '0);
  assign abs1      = (signed_op && src1[WIDTH-1]) ? -src1 : src1;
  assign abs2      = (signed_op && src2[WIDTH-1]) ? -src2 : src2;

  assign prod_fix  = neg_res ? -acc : acc;
  assign quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (step_acc),
    .qbit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_md) state_nxt = dz_now ? FIX : CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0; lo <= '0; done <= 1'b0; cnt <= '0;
      acc <= '0; opnd <= '0; is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (op)
            MDU_MTHI: hi <= src1;
            MDU_MTLO: lo <= src1;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              is_div  <= div_op;
              cnt     <= dz_now ? '0 : CNT_W'(WIDTH);
              opnd    <= div_op ? abs2 : abs1;
              // Divide-by-zero pre-loads the final HI/LO image and skips sign fix-up.
              neg_res <= !dz_now && signed_op && (src1[WIDTH-1] ^ src2[WIDTH-1]);
              neg_rem <= !dz_now && signed_op && src1[WIDTH-1];
              if (dz_now)      acc <= {src1, {WIDTH{1'b1}}};
              else if (div_op) acc <= {{WIDTH{1'b0}}, abs1};
              else             acc <= {{WIDTH{1'b0}}, abs2};
            end
            default: ;
          endcase
        end
        CALC: begin
          acc <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: if (!flush) begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32 and WIDTH=16 with a done-driven scoreboard.
module tb_mdu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, op_valid, flush, op_ready, busy, done;
  logic [2:0]  op;
  logic [31:0] src1, src2, hi, lo;

  logic        v16, f16, r16, b16, d16;
  logic [2:0]  op16;
  logic [15:0] a16, c16, hi16, lo16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp16_q[$];

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .src1(src1), .src2(src2), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .op_valid(v16), .op_ready(r16), .op(op16),
    .src1(a16), .src2(c16), .flush(f16), .busy(b16), .done(d16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("hi_lo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && d16) begin
      if (exp16_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done16: got done=1 hi=%h lo=%h expected no done", hi16, lo16);
      end else begin
        check("hi_lo16", {32'd0, hi16, lo16}, {32'd0, exp16_q.pop_front()});
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
    int n, nb;
    @(negedge clk);
    check("ready_before", 64'(op_ready), 64'd1);
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    exp_q.push_back(exp);
    @(negedge clk);
    op_valid = 1'b0;
    n = 1; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(nb), 64'(lat - 1));
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    v16 = 1'b1; op16 = o; a16 = a; c16 = b;
    exp16_q.push_back(exp);
    @(negedge clk);
    v16 = 1'b0;
    n = 1;
    while (!d16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("latency16", 64'(n), 64'(lat));
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; flush = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    v16 = 1'b0; f16 = 1'b0; op16 = 3'd0; a16 = '0; c16 = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(op_ready), 64'd1);
    resetn = 1'b1;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34);
    run_op(3'd0, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 34);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
    run_op(3'd3, 32'd1000,     32'd7,        64'h00000006_0000008E, 34);
    run_op(3'd3, 32'd100,      32'd0,        64'h00000064_FFFFFFFF, 2);
    run_op(3'd2, 32'hFFFFFF9C, 32'd0,        64'hFFFFFF9C_FFFFFFFF, 2);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);

    // MTHI then MTLO back to back
    @(negedge clk);
    op_valid = 1'b1; op = 3'd4; src1 = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_ready", 64'(op_ready), 64'd1);
    check("mthi_done", 64'(done), 64'd0);
    op = 3'd5; src1 = 32'h9ABCDEF0;
    @(negedge clk);
    op_valid = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
    check("mtlo_hi", 64'(hi), 64'h12345678);
    check("mtlo_ready", 64'(op_ready), 64'd1);
    check("mtlo_done", 64'(done), 64'd0);

    // Reserved opcode, then MTHI blocked by flush in IDLE
    op_valid = 1'b1; op = 3'd6; src1 = 32'h55;
    @(negedge clk);
    check("op6_busy", 64'(busy), 64'd0);
    check("op6_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    op = 3'd4; src1 = 32'hDEAD; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_hi", 64'(hi), 64'h12345678);

    // Flush mid-CALC
    op_valid = 1'b1; op = 3'd3; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_calc_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_ready", 64'(op_ready), 64'd1);
    check("flush_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    repeat (40) @(negedge clk);
    run_op(3'd1, 32'd6, 32'd7, 64'h00000000_0000002A, 34);

    // Reset mid-CALC
    op_valid = 1'b1; op = 3'd1; src1 = 32'd5; src2 = 32'd5;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    resetn = 1'b1;

    run16(3'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 18);
    run16(3'd2, 16'hFFF9, 16'd2,    32'hFFFF_FFFD, 18);
    run16(3'd3, 16'd50,   16'd0,    32'h0032_FFFF, 2);

    repeat (3) @(negedge clk);
    check("pending32", 64'(exp_q.size()), 64'd0);
    check("pending16", 64'(exp16_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
